// File: rtl/dsp_fetch.sv
// Instruction fetch stage: owns the PC, issues pipelined imem reads, buffers words with their PC.
// Latency: response to decode 1 cycle; steady state one instruction per cycle.
// Backpressure: reads are issued only while FIFO plus in-flight reads leave room; jumps flush and drop in-flight words.

// Small prefetch FIFO with synchronous flush; storage is reset so the head reads 0 out of reset.
// Latency: a push is visible at the head the next cycle.
// Backpressure: none internally; the producer reserves space, so a push while full is an error.
module dsp_fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push_vld,
  input  logic [W-1:0]                 push_dat,
  input  logic                         pop,
  output logic [W-1:0]                 head_dat,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign head_dat = mem[rd_ptr];

  // Pointer and occupancy tracking; a flush empties the queue without touching storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + AW'(1);
      if (pop)      rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_vld) - CW'(pop);
    end
  end

  // Entry storage, cleared on reset so the presented word and PC read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_vld && !flush) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // A push into a full FIFO means the upstream space reservation is broken.
  always_ff @(posedge clk) begin
    if (rst_n) assert (!(push_vld && !pop && !flush && count == CW'(DEPTH)));
  end
endmodule

module dsp_fetch #(
  parameter int                ADDR_W     = 16,
  parameter int                INSTR_W    = 16,
  parameter int                DEPTH      = 4,
  parameter int                MAX_OUT    = 2,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               jump_flag,
  input  logic [ADDR_W-1:0]  jump_addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc
);
  localparam int CW = $clog2(DEPTH+1);

  logic [ADDR_W-1:0]         pc;
  logic [ADDR_W-1:0]         resp_pc;
  logic [CW-1:0]             outstanding;
  logic [CW-1:0]             drop_cnt;
  logic [CW-1:0]             fifo_count;
  logic                      grant;
  logic                      push;
  logic                      pop;
  logic [INSTR_W+ADDR_W-1:0] head;

  // Issue only when both the read limit and the FIFO reservation allow it; silent in reset and on a jump.
  assign imem_req  = rst_n & ~jump_flag
                   & (outstanding < CW'(MAX_OUT))
                   & ((fifo_count + outstanding) < CW'(DEPTH));
  assign imem_addr = pc;
  assign grant     = imem_req & imem_gnt;

  // A response is kept only when it is not owed to an earlier redirect and no redirect is happening now.
  assign push = imem_rvalid & (drop_cnt == '0) & ~jump_flag;

  assign instr_valid       = (fifo_count != '0) & ~jump_flag;
  assign pop               = instr_valid & instr_ready;
  assign {instr, instr_pc} = head;

  dsp_fetch_fifo #(
    .W     (INSTR_W + ADDR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (jump_flag),
    .push_vld (push),
    .push_dat ({imem_rdata, resp_pc}),
    .pop      (pop),
    .head_dat (head),
    .count    (fifo_count)
  );

  // PC, response PC, in-flight count and wrong-path drop count; a jump redirects both PCs and
  // marks every read still in flight (minus the one landing now, dropped anyway) for discard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_ADDR;
      resp_pc     <= RESET_ADDR;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(grant) - CW'(imem_rvalid);
      if (jump_flag) begin
        pc       <= jump_addr;
        resp_pc  <= jump_addr;
        drop_cnt <= outstanding - CW'(imem_rvalid);
      end else begin
        if (grant) pc <= pc + ADDR_W'(1);
        if (push) begin
          resp_pc <= resp_pc + ADDR_W'(1);
        end else if (imem_rvalid && drop_cnt != '0) begin
          drop_cnt <= drop_cnt - CW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_dsp_fetch.sv
// Directed bench for dsp_fetch with a 1-cycle-latency in-order memory model.
// Latency: checks sampled 2-3 time units after the rising edge.
// Backpressure: response delivery and decode ready are steered per step.
module tb_dsp_fetch;
  logic        clk;
  logic        rst_n;
  logic        jump_flag;
  logic [15:0] jump_addr;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] instr_pc;

  int          n_err = 0;
  int          n_chk = 0;
  logic        rsp_en;
  logic [15:0] pend[$];
  logic [15:0] ep;

  dsp_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .jump_flag   (jump_flag),
    .jump_addr   (jump_addr),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: every address holds a distinct word.
  function automatic logic [15:0] md(input logic [15:0] a);
    return a ^ 16'hC35A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: record the grant seen this cycle, then after the edge present the oldest pending response.
  task automatic tick();
    @(negedge clk);
    if (rst_n && imem_req && imem_gnt) pend.push_back(imem_addr);
    @(posedge clk);
    #1;
    if (rsp_en && pend.size() > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = md(pend.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pend.delete();
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    jump_flag   = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; jump_flag = 1'b0; jump_addr = '0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; instr_ready = 1'b0; rsp_en = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_req",   imem_req,    0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr,       0);
    chk("rst_pc",    instr_pc,    0);

    // Free-running fetch from reset.
    imem_gnt = 1'b1; instr_ready = 1'b1;
    tick(); rst_n = 1'b1; #1;
    chk("t1_req0",   imem_req,    1);
    chk("t1_addr0",  imem_addr,   0);
    chk("t1_valid0", instr_valid, 0);
    tick(); #1;
    chk("t1_addr1",  imem_addr,   1);
    chk("t1_valid1", instr_valid, 0);
    for (int k = 2; k < 8; k++) begin
      tick(); #1;
      chk("t1_valid", instr_valid, 1);
      chk("t1_pc",    instr_pc,    32'(k - 2));
      chk("t1_instr", instr,       32'(md(16'(k - 2))));
      chk("t1_addr",  imem_addr,   32'(k));
    end

    // Decode stalled: four words buffered, then drained in order.
    instr_ready = 1'b0;
    do_reset();
    for (int c = 0; c < 5; c++) tick();
    #1;
    chk("t2_req_full",  imem_req,    0);
    chk("t2_valid",     instr_valid, 1);
    chk("t2_head_pc0",  instr_pc,    0);
    chk("t2_head_d0",   instr,       32'(md(16'h0000)));
    tick(); tick(); #1;
    chk("t2_req_hold",  imem_req,    0);
    chk("t2_head_hold", instr_pc,    0);
    tick(); instr_ready = 1'b1; #1;
    chk("t2_req_pop",   imem_req,    0);
    chk("t2_pop_pc0",   instr_pc,    0);
    tick(); #1;
    chk("t2_resume_req",  imem_req,  1);
    chk("t2_resume_addr", imem_addr, 4);
    chk("t2_pc1",         instr_pc,  1);
    for (int p = 2; p < 6; p++) begin
      tick(); #1;
      chk("t2_drain_valid", instr_valid, 1);
      chk("t2_drain_pc",    instr_pc,    32'(p));
      chk("t2_drain_instr", instr,       32'(md(16'(p))));
    end

    // Jump with reads for 5 and 6 in flight.
    do_reset();
    for (int c = 0; c < 5; c++) tick();
    rsp_en = 1'b0; #1;
    chk("t3_pc3", instr_pc, 3);
    tick(); tick(); #1;
    chk("t3_req_sat", imem_req,    0);
    chk("t3_valid_e", instr_valid, 0);
    jump_flag = 1'b1; jump_addr = 16'h0040; rsp_en = 1'b1; #1;
    chk("t3_jmp_req", imem_req, 0);
    tick(); jump_flag = 1'b0; #1;
    chk("t3_c8_req",   imem_req,    0);
    chk("t3_c8_valid", instr_valid, 0);
    tick(); #1;
    chk("t3_c9_req",   imem_req,    1);
    chk("t3_c9_addr",  imem_addr,   32'h40);
    chk("t3_c9_valid", instr_valid, 0);
    tick(); #1;
    chk("t3_c10_valid", instr_valid, 0);
    chk("t3_c10_addr",  imem_addr,   32'h41);
    tick(); #1;
    chk("t3_c11_valid", instr_valid, 1);
    chk("t3_c11_pc",    instr_pc,    32'h40);
    chk("t3_c11_instr", instr,       32'(md(16'h0040)));

    // Jump coincident with a response and one more read in flight.
    instr_ready = 1'b0;
    do_reset();
    tick(); rsp_en = 1'b0;
    tick(); tick(); rsp_en = 1'b1; #1;
    chk("t4_c3_valid", instr_valid, 1);
    chk("t4_c3_req",   imem_req,    0);
    tick();
    jump_flag = 1'b1; jump_addr = 16'h0080; #1;
    chk("t4_jmp_valid", instr_valid, 0);
    chk("t4_jmp_req",   imem_req,    0);
    tick(); jump_flag = 1'b0; instr_ready = 1'b1; #1;
    chk("t4_c5_req",   imem_req,    1);
    chk("t4_c5_addr",  imem_addr,   32'h80);
    chk("t4_c5_valid", instr_valid, 0);
    tick(); #1;
    chk("t4_c6_valid", instr_valid, 0);
    chk("t4_c6_addr",  imem_addr,   32'h81);
    tick(); #1;
    chk("t4_c7_valid", instr_valid, 1);
    chk("t4_c7_pc",    instr_pc,    32'h80);
    chk("t4_c7_instr", instr,       32'(md(16'h0080)));

    // Jump near the top of the address space and wrap.
    tick();
    jump_flag = 1'b1; jump_addr = 16'hFFFE; #1;
    chk("t5_jmp_req",   imem_req,    0);
    chk("t5_jmp_valid", instr_valid, 0);
    tick(); jump_flag = 1'b0; #1;
    chk("t5_req",  imem_req,  1);
    chk("t5_addr", imem_addr, 32'hFFFE);
    tick(); #1;
    chk("t5_addr_ffff", imem_addr, 32'hFFFF);
    ep = 16'hFFFE;
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      chk("t5_valid", instr_valid, 1);
      chk("t5_pc",    instr_pc,    32'(ep));
      chk("t5_instr", instr,       32'(md(ep)));
      chk("t5_addr",  imem_addr,   32'(16'(ep + 16'd2)));
      ep = ep + 16'd1;
    end

    // Reset with two reads in flight and the FIFO half full.
    instr_ready = 1'b0;
    do_reset();
    tick(); tick(); rsp_en = 1'b0;
    tick(); tick(); #1;
    chk("t6_pre_valid", instr_valid, 1);
    chk("t6_pre_pc",    instr_pc,    0);
    chk("t6_pre_req",   imem_req,    0);
    rst_n = 1'b0; #1;
    chk("t6_rst_req",   imem_req,    0);
    chk("t6_rst_valid", instr_valid, 0);
    chk("t6_rst_instr", instr,       0);
    chk("t6_rst_pc",    instr_pc,    0);
    pend.delete(); imem_rvalid = 1'b0; imem_rdata = '0;
    tick(); rsp_en = 1'b1; instr_ready = 1'b1; rst_n = 1'b1; #1;
    chk("t6_rel_req",  imem_req,  1);
    chk("t6_rel_addr", imem_addr, 0);
    tick(); tick(); #1;
    chk("t6_valid", instr_valid, 1);
    chk("t6_pc",    instr_pc,    0);
    chk("t6_instr", instr,       32'(md(16'h0000)));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
